rnd_harvester: RTL and testbench
================================

// Module: rnd_harvester
// PURPOSE
//  Consumer end of the latch-based random bit sources. Drives their shared G line,
//  releasing them into random mode and then freezing them. Samples their raw outputs
//  through a synchronizer and XOR-folds them into one bit per sample.
//  Von Neumann debiases that bit stream and packs accepted bits into OUT_W-bit words.
//  Words leave on a valid/ready stream toward the core logic.
// PARAMETERS
//  RAW_W     8   number of raw latch outputs sampled (raw_i width)
//  OUT_W     8   output word width
//  SETTLE    4   cycles gen_o held 0 (random mode) per sample, >=1
//  SYNC_CYC  3   cycles after freeze before sampling, >=2 (covers 2-flop sync)
//  REP_LIMIT 16  repetition-test threshold (used only with RND_HEALTH_EN)
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  en_i         in   1      harvesting enable
//  raw_i        in   RAW_W  raw latch outputs, asynchronous, unconstrained
//  gen_o        out  1      latch G: 0=random mode, 1=freeze
//  out_data_o   out  OUT_W  harvested word
//  out_valid_o  out  1      out_data_o valid
//  out_ready_i  in   1      consumer accepts word when valid&ready
//  health_fail_o out 1      sticky repetition-test failure (0 if feature off)
// BEHAVIOUR
//  Reset (async assert, sync release): gen_o=1, out_valid_o=0, out_data_o=0,
//   health_fail_o=0, FSM=IDLE, accumulator and bit count=0, pair register empty.
//  raw_i passes continuously through a 2-flop synchronizer per bit.
//  FSM states and transitions:
//   IDLE:   gen_o=1; go to ARM when en_i=1 and the accumulator is not full.
//   ARM:    gen_o=0 for exactly SETTLE cycles, then WAIT.
//   WAIT:   gen_o=1 for exactly SYNC_CYC cycles, then SAMPLE.
//   SAMPLE: 1 cycle, gen_o=1; s = ^sync_raw. Then go to ARM if en_i=1 and
//           the accumulator is not full; otherwise go to IDLE.
//  One sample per SETTLE+SYNC_CYC+1 cycles (8 with defaults).
//  Debias on sample pairs (1st,2nd): 01->0, 10->1, 00/11->discard.
//   The pair register empties after each pair; pairs never overlap.
//  Accepted bits shift in LSB-first: 1st accepted bit -> bit 0.
//  At the OUT_W-th bit the word moves to the output register if that register is
//   empty or being handed off this cycle. In that case out_valid_o=1 next cycle
//   and the accumulator clears.
//   Otherwise the accumulator stays full and the FSM parks in IDLE (no sampling).
//   It resumes the cycle after the handoff.
//  Output register: out_data_o is stable while valid&!ready.
//   On valid&ready it is refilled the same edge if a word is pending, else valid drops.
//  en_i=0 mid-sequence: the current ARM/WAIT/SAMPLE completes, then IDLE.
//   Accumulator, pair state and output register are retained.
//  Reset mid-operation: all state is discarded; the partial word is lost.
// CONFIGURATION
//  RND_HEALTH_EN defined: a run counter tracks consecutive equal samples s.
//   On reaching REP_LIMIT, health_fail_o=1, sticky until reset.
//   While failed: the FSM stays in IDLE, and out_valid_o drains the current word,
//   then stays 0.
//  RND_HEALTH_EN undefined: no counter; health_fail_o tied 0.
// TESTING
//  Reset: rst_n=0 mid-ARM -> gen_o=1, out_valid_o=0 immediately, same cycle.
//   After release the next ARM starts with an empty accumulator.
//  Timing: en_i=1 with defaults -> gen_o low 4 cycles, high 4, period 8; 16 samples per word.
//  Debias: force samples 0,1 repeated -> after 16 samples out_data_o=0x00.
//   Force samples 1,0 repeated -> 0xFF.
//   Force samples 0,1,1,0,0,0,1,1 repeating -> 0x?? pattern 0b...10 (discards skipped).
//  Backpressure: out_ready_i=0, alternating pattern -> first word held.
//   After the 2nd word completes, gen_o stays 1 and no ARM occurs.
//   ready=1 for 1 cycle -> 2nd word shows next cycle, sampling resumes.
//  Health (RND_HEALTH_EN, REP_LIMIT=16): raw_i=0xFF constant gives s=0 always
//   -> out_valid_o never rises; health_fail_o=1 after the 16th sample.
//   Without the macro, health_fail_o stays 0.
//  en_i drop: deassert during WAIT -> that SAMPLE occurs, then IDLE with gen_o=1.
//   Re-enable -> the word completes with the correct bit count.

Source files
------------

// File: rtl/rnd_harvester.sv
// rtl/rnd_harvester.sv - random bit harvester for latch-based entropy sources
//
// Drives the shared G line of the latch sources (gen_o: 0 = random mode,
// 1 = freeze), samples their raw outputs through a 2-flop synchronizer,
// XOR-folds them into one bit per sample, Von Neumann debiases the bit
// stream and packs accepted bits LSB-first into OUT_W-bit words.
//
// Optional feature: define RND_HEALTH_EN to add a repetition-count health
// test (sticky health_fail_o, harvesting stops and output drains).
//
// Ports:
//   clk           in   1      clock
//   rst_n         in   1      asynchronous active-low reset
//   en_i          in   1      harvesting enable
//   raw_i         in   RAW_W  raw latch outputs (asynchronous)
//   gen_o         out  1      latch G line
//   out_data_o    out  OUT_W  harvested word
//   out_valid_o   out  1      out_data_o valid
//   out_ready_i   in   1      consumer ready
//   health_fail_o out  1      sticky repetition-test failure
module rnd_harvester #(
  parameter int RAW_W     = 8,
  parameter int OUT_W     = 8,
  parameter int SETTLE    = 4,
  parameter int SYNC_CYC  = 3,
  parameter int REP_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [RAW_W-1:0] raw_i,
  output logic             gen_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             health_fail_o
);

  localparam int TMAX = (SETTLE > SYNC_CYC) ? SETTLE : SYNC_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CNW  = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_SAMPLE} state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      tcnt;
  logic [RAW_W-1:0]   sync1, sync2;
  logic               have_first, first_bit;
  logic [OUT_W-1:0]   acc;
  logic [CNW-1:0]     cnt;
  logic               pending;
  logic               s, do_sample, bit_ok, word_done;
  logic               can_load, full_nxt;
  logic [OUT_W-1:0]   acc_shift;
  logic               fail, fail_nxt;

  // Raw latch outputs are fully asynchronous: two flops per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
    end
  end

  assign s         = ^sync2;
  assign do_sample = (state == S_SAMPLE);
  // Von Neumann: a differing pair yields its first bit, equal pairs are dropped.
  assign bit_ok    = do_sample && have_first && (first_bit != s);
  assign acc_shift = acc | (OUT_W'(first_bit) << cnt);
  assign word_done = bit_ok && (cnt == CNW'(OUT_W - 1));
  assign can_load  = (!out_valid_o || out_ready_i) && !fail;
  // Accumulator will hold a finished word that could not be handed off.
  assign full_nxt  = pending ? !can_load : (word_done && !can_load);

`ifdef RND_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);
  logic          last_s, have_last;
  logic [RW-1:0] run, run_nxt;

  assign run_nxt  = (have_last && (s == last_s)) ? run + RW'(1) : RW'(1);
  assign fail_nxt = fail || (do_sample && (run_nxt >= RW'(REP_LIMIT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_s    <= 1'b0;
      have_last <= 1'b0;
      run       <= '0;
      fail      <= 1'b0;
    end else begin
      if (do_sample) begin
        last_s    <= s;
        have_last <= 1'b1;
        run       <= run_nxt;
      end
      fail <= fail_nxt;
    end
  end
`else
  assign fail     = 1'b0;
  assign fail_nxt = 1'b0;
`endif

  assign health_fail_o = fail;

  // State register and phase timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE) tcnt <= '0;
      else                                        tcnt <= tcnt + TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (en_i && !pending && !fail) state_nxt = S_ARM;
      S_ARM:    if (tcnt == TW'(SETTLE - 1))   state_nxt = S_WAIT;
      S_WAIT:   if (tcnt == TW'(SYNC_CYC - 1)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (en_i && !full_nxt && !fail_nxt) ? S_ARM : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gen_o = 1'b1;
    if (state == S_ARM) gen_o = 1'b0;
  end

  // Pair register, accumulator and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_first  <= 1'b0;
      first_bit   <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      pending     <= 1'b0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (do_sample) begin
        have_first <= !have_first;
        if (!have_first) first_bit <= s;
      end

      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;

      if (pending) begin
        if (can_load) begin
          out_data_o  <= acc;
          out_valid_o <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          pending     <= 1'b0;
        end
      end else if (word_done) begin
        if (can_load) begin
          out_data_o  <= acc_shift;
          out_valid_o <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          acc     <= acc_shift;
          pending <= 1'b1;
        end
      end else if (bit_ok) begin
        acc <= acc_shift;
        cnt <= cnt + CNW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rnd_harvester.sv
// tb/tb_rnd_harvester.sv - directed self-checking bench for rnd_harvester
module tb_rnd_harvester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i;
  logic [7:0] raw_i;
  logic       gen_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       health_fail_o;

  int checks = 0;
  int errors = 0;

  rnd_harvester dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .raw_i         (raw_i),
    .gen_o         (gen_o),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .health_fail_o (health_fail_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample: wait for ARM, present raw value, wait for freeze.
  task automatic smp(input logic [7:0] r, input bit last);
    int n;
    en_i = 1'b1;
    n = 0;
    while (gen_o !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("arm_timeout", 32'(n), 0);
    raw_i = r;
    n = 0;
    while (gen_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("freeze_timeout", 32'(n), 0);
    if (last) en_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk(tag, 32'(out_valid_o), 1);
  endtask

  task automatic pulse_ready();
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  initial begin
    int n;
    int lo;
    int hi;
    logic [7:0] pat;
    bit saw_low;

    rst_n = 1'b0; en_i = 1'b0; raw_i = 8'h00; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gen", 32'(gen_o), 1);
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_data", 32'(out_data_o), 0);
    chk("rst_health", 32'(health_fail_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Timing: ARM length and freeze length.
    en_i = 1'b1;
    n = 0;
    while (gen_o !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    lo = 0;
    while (gen_o === 1'b0 && lo < 20) begin @(negedge clk); lo++; end
    hi = 0;
    while (gen_o === 1'b1 && hi < 20) begin @(negedge clk); hi++; end
    chk("gen_low_cycles", 32'(lo), 4);
    chk("gen_high_cycles", 32'(hi), 4);

    // Reset mid-ARM takes effect immediately.
    chk("in_arm", 32'(gen_o), 0);
    rst_n = 1'b0;
    #1;
    chk("midarm_rst_gen", 32'(gen_o), 1);
    chk("midarm_rst_valid", 32'(out_valid_o), 0);
    en_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Debias 0,1 repeated -> 0x00.
    for (int i = 0; i < 16; i++) smp((i % 2 == 0) ? 8'h00 : 8'h01, i == 15);
    wait_valid("v_01");
    chk("data_01", 32'(out_data_o), 32'h00);
    pulse_ready();
    chk("drop_01", 32'(out_valid_o), 0);

    // Debias 1,0 repeated -> 0xFF.
    for (int i = 0; i < 16; i++) smp((i % 2 == 0) ? 8'h01 : 8'h00, i == 15);
    wait_valid("v_10");
    chk("data_10", 32'(out_data_o), 32'hFF);
    pulse_ready();
    chk("drop_10", 32'(out_valid_o), 0);

    // 0,1,1,0,0,0,1,1 repeating -> bits 0,1,0,1,... -> 0xAA.
    pat = 8'b1100_0110;
    for (int i = 0; i < 32; i++) smp({7'd0, pat[i % 8]}, i == 31);
    wait_valid("v_mix");
    chk("data_mix", 32'(out_data_o), 32'hAA);
    pulse_ready();
    chk("drop_mix", 32'(out_valid_o), 0);

    // en_i drop after 4 bits; resume and finish the word.
    for (int i = 0; i < 8; i++) smp((i % 2 == 0) ? 8'h01 : 8'h00, i == 7);
    repeat (12) @(negedge clk);
    chk("endrop_gen", 32'(gen_o), 1);
    chk("endrop_valid", 32'(out_valid_o), 0);
    for (int i = 0; i < 8; i++) smp((i % 2 == 0) ? 8'h00 : 8'h01, i == 7);
    wait_valid("v_endrop");
    chk("data_endrop", 32'(out_data_o), 32'h0F);
    pulse_ready();

    // Backpressure: word 1 held, word 2 parks the FSM.
    for (int i = 0; i < 16; i++) smp((i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) smp((i % 2 == 0) ? 8'h00 : 8'h01, 1'b0);
    saw_low = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (gen_o !== 1'b1) saw_low = 1'b1;
    end
    chk("bp_parked", 32'(saw_low), 0);
    chk("bp_valid", 32'(out_valid_o), 1);
    chk("bp_word1", 32'(out_data_o), 32'hFF);
    pulse_ready();
    chk("bp_valid2", 32'(out_valid_o), 1);
    chk("bp_word2", 32'(out_data_o), 32'h00);
    n = 0;
    while (gen_o !== 1'b0 && n < 6) begin @(negedge clk); n++; end
    chk("bp_resume", 32'(gen_o), 0);
    en_i = 1'b0;

    // Health: constant raw 0xFF gives s=0 forever.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) smp(8'hFF, i == 15);
    chk("health_pre", 32'(health_fail_o), 0);
    repeat (10) @(negedge clk);
`ifdef RND_HEALTH_EN
    chk("health_fail", 32'(health_fail_o), 1);
`else
    chk("health_off", 32'(health_fail_o), 0);
`endif
    chk("health_novalid", 32'(out_valid_o), 0);
    out_ready_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
